i2c_read_scheduler: RTL and testbench
=====================================

I2C_READ_SCHEDULER -- requirements
Module: i2c_read_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_REQ, 4, number of requesters (2..8).
REQ-002 The block SHALL have parameter DEV_W, 7, device-address width.
REQ-003 The block SHALL have parameter ADDR_W, 8, data-address width.
REQ-004 The block SHALL have parameter DATA_W, 8, read-data width.
REQ-005 The block SHALL have parameter TIMEOUT, 65535, maximum number of WAIT-state cycles before abort.
REQ-006 The block SHALL have one clock and an asynchronous active-low reset, with ports clk and rst_n.
REQ-007 clk  input  1  system clock; all state changes on its rising edge.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 i_req  input  NUM_REQ  per-requester read request, level, held until o_ack.
REQ-010 i_dev_addr  input  NUM_REQ*DEV_W  packed device addresses; requester k occupies slice k.
REQ-011 i_data_addr  input  NUM_REQ*ADDR_W  packed data addresses; requester k occupies slice k.
REQ-012 o_ack  output  NUM_REQ  one-hot, one-cycle acceptance pulse.
REQ-013 o_rsp_valid  output  NUM_REQ  one-hot, one-cycle response pulse.
REQ-014 o_rsp_data  output  DATA_W  shared response data, valid with o_rsp_valid.
REQ-015 o_rsp_err  output  1  timeout flag, valid with o_rsp_valid.
REQ-016 o_busy  output  1  high whenever state is not IDLE.
REQ-017 o_recv_en  output  1  one-cycle start pulse to the I2C receive master.
REQ-018 o_device_addr  output  DEV_W  device address driven to the master.
REQ-019 o_data_addr  output  ADDR_W  data address driven to the master.
REQ-020 i_read_data  input  DATA_W  read data returned by the master.
REQ-021 i_done_flag  input  1  master completion pulse.

Function
REQ-022 The FSM SHALL have the states IDLE, WAIT and RESP; all outputs SHALL be registered.
REQ-023 In IDLE with i_req nonzero, the block SHALL grant by round-robin: the first requester at or after rr_ptr (wrapping NUM_REQ-1 -> 0).
REQ-024 On grant g, in the next cycle: o_ack[g]=1, o_recv_en=1, o_device_addr/o_data_addr = the slices of requester g latched at grant, state = WAIT, timer = 0.
REQ-025 o_device_addr and o_data_addr SHALL stay stable from issue until the block returns to IDLE.
REQ-026 In WAIT, the timer SHALL increment each cycle; i_done_flag=1 SHALL capture i_read_data and move to RESP with err=0.
REQ-027 In WAIT, a timer value of TIMEOUT-1 without i_done_flag SHALL move to RESP with err=1 and data=0.
REQ-028 If i_done_flag and the timeout coincide, done SHALL win (err=0).
REQ-029 In RESP, the block SHALL pulse o_rsp_valid[g] for one cycle with o_rsp_data/o_rsp_err, set rr_ptr=(g+1) mod NUM_REQ, and return to IDLE.
REQ-030 i_done_flag outside WAIT SHALL be ignored; i_req is sampled only in IDLE.
REQ-031 A request dropped before its o_ack SHALL be treated as withdrawn, with no side effects.
REQ-032 Minimum turnaround SHALL be 3 cycles (grant -> WAIT -> RESP -> IDLE); at most one transaction SHALL be outstanding.

Reset
REQ-033 While rst_n=0, the block SHALL hold: state=IDLE, rr_ptr=0, timer=0, all outputs 0.
REQ-034 A reset mid-transaction SHALL abort it with no o_rsp_valid, and a subsequent i_done_flag SHALL be ignored.

Structure
REQ-035 Package i2c_sched_pkg SHALL hold the FSM state encoding and the default widths and TIMEOUT.
REQ-036 The round-robin selector SHALL be sub-module rr_arbiter (inputs req and ptr; outputs one-hot grant and index).

Verification
REQ-037 Single request: i_req=0001, dev 0x50, addr 0x10, done after 20 cycles with data 0xA5 -> o_ack[0], o_recv_en once, o_rsp_valid[0], data 0xA5, err 0.
REQ-038 Simultaneous requests: i_req=1111 held -> grant order 0,1,2,3,0, with one response each.
REQ-039 Timeout: TIMEOUT=16, no done -> o_rsp_valid with err=1 and data 0x00 exactly 16 cycles after o_recv_en.
REQ-040 Coincident done and timeout on the same cycle -> err=0 and data captured.
REQ-041 Reset asserted in WAIT -> all outputs 0, a later done ignored, and the next request is granted from rr_ptr=0.
REQ-042 A stray i_done_flag in IDLE, and addresses changed during WAIT -> no response, and o_device_addr/o_data_addr unchanged.

Source files
------------

// File: rtl/i2c_sched_pkg.sv
// Shared FSM encoding and default sizing for the I2C read scheduler.
package i2c_sched_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DEV_W   = 7;
  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_TIMEOUT = 65535;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // The WAIT timer only has to reach TIMEOUT-1.
  function automatic int timer_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first asserted request at or after ptr.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] index
);

  int k;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    grant = '0;
    index = '0;
    k     = 0;
    // Scan from the farthest offset down so the closest hit is written last.
    for (int i = N - 1; i >= 0; i--) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (req[k]) begin
        grant    = '0;
        grant[k] = 1'b1;
        index    = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/i2c_read_scheduler.sv
// Round-robin scheduler that issues one I2C read at a time on behalf of
// NUM_REQ requesters and routes the result (or a timeout) back to the owner.
module i2c_read_scheduler
  import i2c_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DEV_W   = DEF_DEV_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          i_req,
  input  logic [NUM_REQ*DEV_W-1:0]    i_dev_addr,
  input  logic [NUM_REQ*ADDR_W-1:0]   i_data_addr,
  output logic [NUM_REQ-1:0]          o_ack,
  output logic [NUM_REQ-1:0]          o_rsp_valid,
  output logic [DATA_W-1:0]           o_rsp_data,
  output logic                        o_rsp_err,
  output logic                        o_busy,
  output logic                        o_recv_en,
  output logic [DEV_W-1:0]            o_device_addr,
  output logic [ADDR_W-1:0]           o_data_addr,
  input  logic [DATA_W-1:0]           i_read_data,
  input  logic                        i_done_flag
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMR_W = timer_width(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [TMR_W-1:0]   timer_q, timer_d;

  logic [NUM_REQ-1:0] ack_d, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_d;
  logic               rsp_err_d, recv_en_d, busy_d;
  logic [DEV_W-1:0]   dev_d;
  logic [ADDR_W-1:0]  daddr_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req   (i_req),
    .ptr   (rr_ptr_q),
    .grant (arb_grant),
    .index (arb_idx)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    timer_d     = timer_q;
    ack_d       = '0;
    rsp_valid_d = '0;
    rsp_data_d  = '0;
    rsp_err_d   = 1'b0;
    recv_en_d   = 1'b0;
    // Addresses hold their last issued value so the master sees a stable bus.
    dev_d       = o_device_addr;
    daddr_d     = o_data_addr;

    unique case (state_q)
      ST_IDLE: begin
        if (|arb_grant) begin
          state_d   = ST_WAIT;
          owner_d   = arb_idx;
          timer_d   = '0;
          ack_d     = arb_grant;
          recv_en_d = 1'b1;
          dev_d     = i_dev_addr[DEV_W*int'(arb_idx) +: DEV_W];
          daddr_d   = i_data_addr[ADDR_W*int'(arb_idx) +: ADDR_W];
        end
      end
      ST_WAIT: begin
        // Done is tested first so a completion on the last timer tick wins.
        if (i_done_flag) begin
          state_d     = ST_RESP;
          timer_d     = '0;
          rsp_valid_d = NUM_REQ'(1) << owner_q;
          rsp_data_d  = i_read_data;
        end else if (timer_q == TMR_LAST) begin
          state_d     = ST_RESP;
          timer_d     = '0;
          rsp_valid_d = NUM_REQ'(1) << owner_q;
          rsp_err_d   = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_RESP: begin
        state_d  = ST_IDLE;
        rr_ptr_d = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      timer_q       <= '0;
      o_ack         <= '0;
      o_rsp_valid   <= '0;
      o_rsp_data    <= '0;
      o_rsp_err     <= 1'b0;
      o_busy        <= 1'b0;
      o_recv_en     <= 1'b0;
      o_device_addr <= '0;
      o_data_addr   <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      timer_q       <= timer_d;
      o_ack         <= ack_d;
      o_rsp_valid   <= rsp_valid_d;
      o_rsp_data    <= rsp_data_d;
      o_rsp_err     <= rsp_err_d;
      o_busy        <= busy_d;
      o_recv_en     <= recv_en_d;
      o_device_addr <= dev_d;
      o_data_addr   <= daddr_d;
    end
  end

endmodule

// File: tb/tb_i2c_read_scheduler.sv
// Self-checking bench: two schedulers (long and short timeout) share stimulus
// and are compared every cycle against a transaction-level model.
module tb_i2c_read_scheduler;

  localparam int N    = 4;
  localparam int DW   = 7;
  localparam int AW   = 8;
  localparam int RW   = 8;
  localparam int TO_A = 64;
  localparam int TO_B = 16;

  typedef struct {
    int             phase;  // 0 idle, 1 read in flight, 2 responding
    int             owner;
    int             age;
    int             ptr;
    logic [N-1:0]   ack;
    logic [N-1:0]   rv;
    logic           recv;
    logic           err;
    logic           busy;
    logic [RW-1:0]  data;
    logic [DW-1:0]  dev;
    logic [AW-1:0]  daddr;
  } model_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic started = 1'b0;
  logic [N-1:0]    i_req;
  logic [N*DW-1:0] i_dev_addr;
  logic [N*AW-1:0] i_data_addr;
  logic [RW-1:0]   i_read_data;
  logic            i_done_flag;

  logic [N-1:0]  ack [2];
  logic [N-1:0]  rsp_valid [2];
  logic [RW-1:0] rsp_data [2];
  logic          rsp_err [2];
  logic          busy [2];
  logic          recv_en [2];
  logic [DW-1:0] dev_addr [2];
  logic [AW-1:0] data_addr [2];

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;

  model_t m [2];
  int recv_cyc [2];
  int lat [2];
  int n_rsp [2];
  int n_recv [2];
  logic [RW-1:0] last_data [2];
  logic last_err [2];
  int grants [2][16];
  int g_n [2];

  i2c_read_scheduler #(.NUM_REQ(N), .DEV_W(DW), .ADDR_W(AW), .DATA_W(RW), .TIMEOUT(TO_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_dev_addr(i_dev_addr), .i_data_addr(i_data_addr),
    .o_ack(ack[0]), .o_rsp_valid(rsp_valid[0]), .o_rsp_data(rsp_data[0]), .o_rsp_err(rsp_err[0]),
    .o_busy(busy[0]), .o_recv_en(recv_en[0]), .o_device_addr(dev_addr[0]), .o_data_addr(data_addr[0]),
    .i_read_data(i_read_data), .i_done_flag(i_done_flag)
  );

  i2c_read_scheduler #(.NUM_REQ(N), .DEV_W(DW), .ADDR_W(AW), .DATA_W(RW), .TIMEOUT(TO_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_dev_addr(i_dev_addr), .i_data_addr(i_data_addr),
    .o_ack(ack[1]), .o_rsp_valid(rsp_valid[1]), .o_rsp_data(rsp_data[1]), .o_rsp_err(rsp_err[1]),
    .o_busy(busy[1]), .o_recv_en(recv_en[1]), .o_device_addr(dev_addr[1]), .o_data_addr(data_addr[1]),
    .i_read_data(i_read_data), .i_done_flag(i_done_flag)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic model_t model_zero();
    model_t z;
    z.phase = 0; z.owner = 0; z.age = 0; z.ptr = 0;
    z.ack = '0; z.rv = '0; z.recv = 1'b0; z.err = 1'b0; z.busy = 1'b0;
    z.data = '0; z.dev = '0; z.daddr = '0;
    return z;
  endfunction

  // One clock of the transaction rules, applied to the inputs seen at the edge.
  function automatic model_t model_step(input model_t s, input int timeout);
    model_t n = s;
    int k;
    n.ack = '0; n.rv = '0; n.recv = 1'b0; n.err = 1'b0; n.data = '0;
    if (s.phase == 0) begin
      for (int i = 0; i < N; i++) begin
        k = (s.ptr + i) % N;
        if (n.phase == 0 && i_req[k]) begin
          n.phase = 1; n.owner = k; n.age = 0;
          n.ack = N'(1 << k); n.recv = 1'b1;
          n.dev = i_dev_addr[k*DW +: DW];
          n.daddr = i_data_addr[k*AW +: AW];
        end
      end
    end else if (s.phase == 1) begin
      if (i_done_flag) begin
        n.phase = 2; n.rv = N'(1 << s.owner); n.data = i_read_data;
      end else if (s.age == timeout - 1) begin
        n.phase = 2; n.rv = N'(1 << s.owner); n.err = 1'b1;
      end else begin
        n.age = s.age + 1;
      end
    end else begin
      n.phase = 0;
      n.ptr = (s.owner + 1) % N;
    end
    n.busy = (n.phase != 0);
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m[0] <= model_zero();
      m[1] <= model_zero();
    end else begin
      m[0] <= model_step(m[0], TO_A);
      m[1] <= model_step(m[1], TO_B);
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  always @(negedge clk) begin
    if (started) begin
      for (int u = 0; u < 2; u++) begin
        check($sformatf("u%0d ack", u), ack[u], m[u].ack);
        check($sformatf("u%0d recv_en", u), recv_en[u], m[u].recv);
        check($sformatf("u%0d rsp_valid", u), rsp_valid[u], m[u].rv);
        check($sformatf("u%0d rsp_data", u), rsp_data[u], m[u].data);
        check($sformatf("u%0d rsp_err", u), rsp_err[u], m[u].err);
        check($sformatf("u%0d busy", u), busy[u], m[u].busy);
        check($sformatf("u%0d device_addr", u), dev_addr[u], m[u].dev);
        check($sformatf("u%0d data_addr", u), data_addr[u], m[u].daddr);
        if (recv_en[u]) begin
          recv_cyc[u] <= cyc;
          n_recv[u] <= n_recv[u] + 1;
          if (g_n[u] < 16) grants[u][g_n[u]] <= onehot_idx(ack[u]);
          g_n[u] <= g_n[u] + 1;
        end
        if (rsp_valid[u] != '0) begin
          lat[u] <= cyc - recv_cyc[u];
          n_rsp[u] <= n_rsp[u] + 1;
          last_data[u] <= rsp_data[u];
          last_err[u] <= rsp_err[u];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy[0] || busy[1]) && n < budget) begin
      tick();
      n++;
    end
    check("idle wait", {busy[0], busy[1]}, 2'b00);
  endtask

  task automatic request(input logic [N-1:0] mask);
    int n = 0;
    i_req = mask;
    tick();
    while (ack[0] == '0 && n < 50) begin
      tick();
      n++;
    end
    check("ack wait", (ack[0] != '0), 1'b1);
  endtask

  // Drives done during cycle d, counting the recv_en cycle as cycle 0.
  task automatic pulse_done(input int d, input logic [RW-1:0] data);
    repeat (d) tick();
    i_done_flag = 1'b1;
    i_read_data = data;
    tick();
    i_done_flag = 1'b0;
    i_read_data = 8'hC3;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, rsp0, rsp1;
    int exp_order [5] = '{0, 1, 2, 3, 0};
    for (int u = 0; u < 2; u++) begin
      recv_cyc[u] = 0; lat[u] = 0; n_rsp[u] = 0; n_recv[u] = 0; g_n[u] = 0;
      last_data[u] = '0; last_err[u] = 1'b0;
    end
    i_req = '0;
    i_done_flag = 1'b0;
    i_read_data = 8'hC3;
    i_dev_addr = {7'h13, 7'h22, 7'h31, 7'h40};
    i_data_addr = 32'h4433_2211;

    #1 rst_n = 1'b0;
    started = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", busy[0], 1'b0);
    check("reset device_addr", dev_addr[0], 7'h00);
    rst_n = 1'b1;
    tick();

    // All four request together: rotation 0,1,2,3,0.
    base = g_n[0];
    for (int i = 0; i < 5; i++) begin
      request(4'hF);
      if (i == 4) i_req = '0;
      pulse_done(1, RW'(8'h30 + i));
    end
    wait_idle(20);
    for (int i = 0; i < 5; i++)
      check($sformatf("rr order %0d", i), grants[0][base + i], exp_order[i]);
    check("rr last data", last_data[0], 8'h34);

    // Single request, done after 20 cycles; the short-timeout unit aborts first.
    i_dev_addr[0 +: DW] = 7'h50;
    i_data_addr[0 +: AW] = 8'h10;
    base = n_recv[0];
    request(4'b0001);
    i_req = '0;
    check("single ack", ack[0], 4'b0001);
    check("single recv_en", recv_en[0], 1'b1);
    check("single dev", dev_addr[0], 7'h50);
    check("single addr", data_addr[0], 8'h10);
    pulse_done(20, 8'hA5);
    wait_idle(40);
    check("single data", last_data[0], 8'hA5);
    check("single err", last_err[0], 1'b0);
    check("single latency", lat[0], 21);
    check("single recv count", n_recv[0] - base, 1);
    check("short-to err", last_err[1], 1'b1);
    check("short-to data", last_data[1], 8'h00);
    check("short-to latency", lat[1], 16);

    // Timeout with no done at all.
    request(4'b0100);
    i_req = '0;
    wait_idle(200);
    check("timeout err B", last_err[1], 1'b1);
    check("timeout data B", last_data[1], 8'h00);
    check("timeout latency B", lat[1], 16);
    check("timeout latency A", lat[0], 64);
    check("timeout err A", last_err[0], 1'b1);

    // Stray done while idle, then address bus churn during WAIT.
    rsp0 = n_rsp[0]; rsp1 = n_rsp[1];
    tick();
    pulse_done(0, 8'hEE);
    repeat (3) tick();
    check("stray done A", n_rsp[0] - rsp0, 0);
    check("stray done B", n_rsp[1] - rsp1, 0);
    i_dev_addr[3*DW +: DW] = 7'h2B;
    i_data_addr[3*AW +: AW] = 8'h9D;
    request(4'b1000);
    i_req = '0;
    tick();
    i_dev_addr = ~i_dev_addr;
    i_data_addr = ~i_data_addr;
    pulse_done(4, 8'h66);
    wait_idle(20);
    check("held dev", dev_addr[0], 7'h2B);
    check("held addr", data_addr[0], 8'h9D);
    check("churn data", last_data[0], 8'h66);

    // Done on the very last timer cycle of the short unit.
    request(4'b0010);
    i_req = '0;
    pulse_done(15, 8'h5C);
    wait_idle(20);
    check("coincide err B", last_err[1], 1'b0);
    check("coincide data B", last_data[1], 8'h5C);
    check("coincide latency B", lat[1], 16);
    check("coincide data A", last_data[0], 8'h5C);

    // Reset in WAIT (rr_ptr is 2 here); then grant must restart from 0.
    request(4'b0100);
    i_req = '0;
    repeat (3) tick();
    rsp0 = n_rsp[0]; rsp1 = n_rsp[1];
    rst_n = 1'b0;
    tick();
    check("reset mid busy", busy[0], 1'b0);
    tick();
    rst_n = 1'b1;
    pulse_done(0, 8'h77);
    repeat (3) tick();
    check("abort no rsp A", n_rsp[0] - rsp0, 0);
    check("abort no rsp B", n_rsp[1] - rsp1, 0);
    base = g_n[0];
    request(4'hF);
    i_req = '0;
    pulse_done(2, 8'h11);
    wait_idle(20);
    check("post-reset grant A", grants[0][base], 0);
    check("post-reset grant B", grants[1][base], 0);

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
